inst_fetch: RTL and testbench

Instruction fetch stage of the Yu Core. Holds the program counter, issues one word-aligned request at a time to instruction memory over a valid/ready handshake, and captures the returned word in an instruction register. The register drives the decode/immediate-extend stage directly. Fields are presented as instruction[6:0] (opcode) and instruction[XLEN-1:7] (immediate source bits for the extender). Handles branch/jump redirects at any point in a fetch, including killing an in-flight response.

---
 rtl/inst_fetch_pkg.sv | 32 +++
 rtl/inst_fetch_program_counter.sv | 46 ++++
 rtl/inst_fetch.sv | 182 ++++++++++++++++++
 tb/tb_inst_fetch.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the Yu Core instruction fetch stage: datapath
// defaults, base opcode constants and the program-counter update selector.
package inst_fetch_pkg;

  localparam int unsigned DEFAULT_XLEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Base opcodes as presented on instruction[6:0] to the decode stage.
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // How the program counter moves on the next edge.
  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  // A fetch target must be word aligned; any set low bit is a fault.
  function automatic logic word_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/inst_fetch_program_counter.sv
// Program counter for the fetch stage: holds pc, increments by one word
// (wrapping modulo 2^XLEN), loads redirect targets and flags misaligned
// redirect targets.
module inst_fetch_program_counter
  import inst_fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  pc_sel_e         sel_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Sequential word increment; the carry out of the top bit is dropped so
  // the last word of the address space wraps to zero.
  assign pc_plus4_o   = pc_q + XLEN'(4);
  assign misaligned_o = word_misaligned(redirect_pc_i[1:0]);
  assign pc_o         = pc_q;

  // Select the next pc: redirect beats increment, otherwise hold.
  always_comb begin
    // NOTE: default assignment first so every path drives pc_d and no latch is inferred.
    pc_d = pc_q;
    unique case (sel_i)
      PC_INC:      pc_d = pc_plus4_o;
      PC_REDIRECT: pc_d = redirect_pc_i;
      default:     pc_d = pc_q;
    endcase
  end

  // pc register with synchronous reset to the boot address.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for state so every register samples pre-edge values.
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one word-aligned request at a time over a
// valid/ready handshake, captures the returned word into the instruction
// register, and handles redirects at any point including killing a response
// that is still in flight. Misaligned redirect targets produce a fault token
// instead of a memory access.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = DEFAULT_RESET_PC[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
  output logic [XLEN-8:0] imm,
  output logic            inst_misaligned
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e          state_q;
  logic            kill_q, kill_d;     // a response is owed but must be dropped
  logic            parked_q;           // IDLE waits for a redirect after a fault
  logic            req_valid_q;
  logic            inst_valid_q;
  logic            misaligned_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] inst_pc_q;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            target_misaligned;
  pc_sel_e         pc_sel;
  logic            accept;
  logic            consume;
  logic            fault_redirect;

  assign accept         = req_valid_q && imem_req_ready;
  assign consume        = (state_q == S_HOLD) && inst_ready;
  assign fault_redirect = redirect_valid && target_misaligned;

  // A normal word is consumed: step to the next sequential word. A consumed
  // fault token leaves pc alone; a redirect always wins over the increment.
  always_comb begin
    pc_sel = PC_HOLD;
    if (redirect_valid)               pc_sel = PC_REDIRECT;
    else if (consume && !misaligned_q) pc_sel = PC_INC;
  end

  inst_fetch_program_counter #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst           (rst),
    .sel_i         (pc_sel),
    .redirect_pc_i (redirect_pc),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4),
    .misaligned_o  (target_misaligned)
  );

  // Track an abandoned request: it is set when a redirect leaves an accepted
  // request without its response, and cleared when that response shows up.
  always_comb begin
    kill_d = kill_q;
    if (kill_q && imem_rsp_valid) kill_d = 1'b0;
    if (redirect_valid) begin
      if ((state_q == S_REQ) && accept)                kill_d = 1'b1;
      else if ((state_q == S_WAIT) && !imem_rsp_valid) kill_d = 1'b1;
    end
  end

  // Fetch FSM with registered request and instruction-register outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      kill_q       <= 1'b0;
      parked_q     <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      instr_q      <= '0;
      inst_pc_q    <= '0;
    end else begin
      kill_q <= kill_d;
      if (fault_redirect) begin
        // Misaligned target: present a fault token, never touch memory.
        state_q      <= S_HOLD;
        parked_q     <= 1'b0;
        req_valid_q  <= 1'b0;
        inst_valid_q <= 1'b1;
        misaligned_q <= 1'b1;
        instr_q      <= '0;
        inst_pc_q    <= redirect_pc;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (redirect_valid || !parked_q) begin
              state_q     <= S_REQ;
              parked_q    <= 1'b0;
              req_valid_q <= !kill_d;
            end
          end
          S_REQ: begin
            if (accept) begin
              state_q     <= S_WAIT;
              req_valid_q <= 1'b0;
            end else begin
              // Request is held back only while a killed response drains.
              req_valid_q <= !kill_d;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              if (kill_q || redirect_valid) begin
                state_q     <= S_REQ;
                req_valid_q <= 1'b1;
              end else begin
                state_q      <= S_HOLD;
                inst_valid_q <= 1'b1;
                misaligned_q <= 1'b0;
                instr_q      <= imem_rsp_data;
                inst_pc_q    <= pc;
              end
            end
          end
          S_HOLD: begin
            if (redirect_valid) begin
              state_q      <= S_REQ;
              inst_valid_q <= 1'b0;
              misaligned_q <= 1'b0;
              req_valid_q  <= !kill_d;
            end else if (inst_ready) begin
              inst_valid_q <= 1'b0;
              misaligned_q <= 1'b0;
              if (misaligned_q) begin
                state_q  <= S_IDLE;
                parked_q <= 1'b1;
              end else begin
                state_q     <= S_REQ;
                req_valid_q <= !kill_d;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign imem_req_valid  = req_valid_q;
  assign imem_addr       = pc & ~XLEN'(3);
  assign inst_valid      = inst_valid_q;
  assign inst_misaligned = misaligned_q;
  assign instruction     = instr_q;
  assign inst_pc         = inst_pc_q;
  assign opcode          = instr_q[6:0];
  assign imm             = instr_q[XLEN-1:7];

  // The incremented pc is only consumed inside the counter; fold it into a
  // reduction so the full vector stays referenced.
  logic pc_plus4_unused;
  assign pc_plus4_unused = ^pc_plus4;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch. A small memory model answers
// every accepted request on the following cycle unless turned off so a step
// can drive the response by hand.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [24:0] imm;
  logic        inst_misaligned;

  int errors = 0;
  int checks = 0;
  bit auto_rsp;

  inst_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .instruction     (instruction),
    .inst_pc         (inst_pc),
    .opcode          (opcode),
    .imm             (imm),
    .inst_misaligned (inst_misaligned)
  );

  always #5 clk = ~clk;

  // Memory contents: 0x0 holds the test word, elsewhere {addr[23:0], 8'h13}.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hA549_A303;
    return {a[23:0], 8'h13};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; inputs and samples settle 1 time unit after the rising edge.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = (imem_req_valid === 1'b1) && (imem_req_ready === 1'b1);
    a   = imem_addr;
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      imem_rsp_valid = acc;
      imem_rsp_data  = acc ? mem_word(a) : 32'h0;
    end
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0; auto_rsp = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_misaligned", 32'(inst_misaligned), 32'd0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_imm", 32'(imm), 32'h0);

    // First fetch at 0x0
    rst = 1'b0;
    tick();
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_addr, 32'h0);
    tick();
    check("wait_req_low", 32'(imem_req_valid), 32'd0);
    check("wait_inst_low", 32'(inst_valid), 32'd0);
    tick();
    check("hold_inst_valid", 32'(inst_valid), 32'd1);
    check("hold_opcode", 32'(opcode), 32'h03);
    check("hold_imm", 32'(imm), 32'h014A_9346);
    check("hold_inst_pc", inst_pc, 32'h0);
    check("hold_instruction", instruction, 32'hA549_A303);
    check("hold_misaligned", 32'(inst_misaligned), 32'd0);

    // Stall in HOLD for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_inst_valid", 32'(inst_valid), 32'd1);
      check("stall_instruction", instruction, 32'hA549_A303);
      check("stall_inst_pc", inst_pc, 32'h0);
      check("stall_no_req", 32'(imem_req_valid), 32'd0);
    end

    // Consume; sequential fetch at 0x4
    inst_ready = 1'b1;
    tick();
    check("seq_req_valid", 32'(imem_req_valid), 32'd1);
    check("seq_req_addr", imem_addr, 32'h4);
    check("seq_inst_dropped", 32'(inst_valid), 32'd0);
    tick(); tick();
    check("seq_inst_valid", 32'(inst_valid), 32'd1);
    check("seq_inst_pc", inst_pc, 32'h4);
    check("seq_instruction", instruction, 32'h0000_0413);
    check("seq_opcode", 32'(opcode), 32'h13);
    tick();
    check("seq2_req_addr", imem_addr, 32'h8);
    check("seq2_req_valid", 32'(imem_req_valid), 32'd1);

    // Redirect to 0x100 while waiting on 0x8; stale response must be dropped
    auto_rsp = 1'b0;
    tick();
    check("kill_wait_req_low", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("kill_still_wait", 32'(imem_req_valid), 32'd0);
    check("kill_no_inst", 32'(inst_valid), 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; auto_rsp = 1'b1;
    check("kill_dropped", 32'(inst_valid), 32'd0);
    check("kill_req_valid", 32'(imem_req_valid), 32'd1);
    check("kill_req_addr", imem_addr, 32'h100);
    tick(); tick();
    check("redir_inst_valid", 32'(inst_valid), 32'd1);
    check("redir_inst_pc", inst_pc, 32'h100);
    check("redir_instruction", instruction, 32'h0001_0013);
    tick();
    check("redir_next_addr", imem_addr, 32'h104);

    // Misaligned redirect while the 0x104 request is being accepted
    inst_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    check("mis_inst_valid", 32'(inst_valid), 32'd1);
    check("mis_flag", 32'(inst_misaligned), 32'd1);
    check("mis_inst_pc", inst_pc, 32'h102);
    check("mis_instruction", instruction, 32'h0);
    check("mis_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    check("mis_hold_no_req", 32'(imem_req_valid), 32'd0);
    check("mis_hold_flag", 32'(inst_misaligned), 32'd1);
    inst_ready = 1'b1;
    tick();
    check("mis_consumed_valid", 32'(inst_valid), 32'd0);
    check("mis_consumed_flag", 32'(inst_misaligned), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("parked_no_req", 32'(imem_req_valid), 32'd0);
      tick();
    end

    // Redirect to the last word; consumption wraps to 0x0
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("top_req_valid", 32'(imem_req_valid), 32'd1);
    check("top_req_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); tick();
    check("top_inst_pc", inst_pc, 32'hFFFF_FFFC);
    check("top_instruction", instruction, 32'hFFFF_FC13);
    tick();
    check("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    check("wrap_req_addr", imem_addr, 32'h0);

    // Reset while waiting; response arrives the cycle after reset
    auto_rsp = 1'b0;
    tick();
    check("rst2_in_wait", 32'(imem_req_valid), 32'd0);
    rst = 1'b1;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hA5A5_0F0F;
    check("rst2_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst2_inst_valid", 32'(inst_valid), 32'd0);
    check("rst2_misaligned", 32'(inst_misaligned), 32'd0);
    check("rst2_instruction", instruction, 32'h0);
    check("rst2_inst_pc", inst_pc, 32'h0);
    rst = 1'b0;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; auto_rsp = 1'b1;
    check("rst2_ignored_rsp", 32'(inst_valid), 32'd0);
    check("rst2_first_req", 32'(imem_req_valid), 32'd1);
    check("rst2_first_addr", imem_addr, 32'h0);
    tick(); tick();
    check("rst2_inst_pc", inst_pc, 32'h0);
    check("rst2_instr_fetched", instruction, 32'hA549_A303);

    // Redirect in HOLD with inst_ready: the target wins over pc+4
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("hold_redir_inst_valid", 32'(inst_valid), 32'd0);
    check("hold_redir_addr", imem_addr, 32'h200);
    check("hold_redir_req_valid", 32'(imem_req_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
